// File: rtl/seg7_capture_encoder.sv
`default_nettype none
// ==========================================================================================
// seg7_capture_encoder: captures a multiplexed active-low 7-seg bus back into hex nibbles.
// Optional blank-digit support via SEG7CAP_BLANK_EN.                           Rev 1.0
// ==========================================================================================
module seg7_capture_encoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    valid,
  output logic                    frame_done,
  output logic                    err
`ifdef SEG7CAP_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0]   blank_mask
`endif
);

  localparam int                   c_sw       = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0]     c_cnt_max  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] c_all_seen = '1;

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_settle   = 2'd1;
  localparam logic [1:0] c_captured = 2'd2;

  logic [c_sw-1:0]         r_sync1;
  logic [c_sw-1:0]         r_samp;
  logic [c_sw-1:0]         r_prev;
  logic [CNT_W-1:0]        r_cnt;
  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic [3:0]              r_shadow [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] w_shadow_flat;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [NUM_DIGITS-1:0]   w_seen_next;
  logic [NUM_DIGITS-1:0]   w_dig;
  logic [6:0]              w_seg;
  logic                    w_changed;
  logic                    w_onehot;
  logic                    w_capture;
  logic                    w_known;
  logic [3:0]              w_nib;
  logic                    w_cap_ok;
  logic                    w_cap_bad;
  logic                    w_publish;
`ifdef SEG7CAP_BLANK_EN
  logic                    w_is_blank;
  logic [NUM_DIGITS-1:0]   r_blank_shadow;
`endif

  // Both buses are asynchronous; they share one two-stage synchroniser so S is one vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_samp  <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {dig_sel, seg_n};
      r_samp  <= r_sync1;
      r_prev  <= r_samp;
    end
  end

  assign w_dig     = r_samp[c_sw-1:7];
  assign w_seg     = r_samp[6:0];
  assign w_changed = (r_samp != r_prev);
  assign w_onehot  = (w_dig != '0) && ((w_dig & (w_dig - NUM_DIGITS'(1))) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_changed) begin
      r_cnt <= '0;
    end else if (r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (w_onehot) w_state_next = c_settle;
      end
      c_settle: begin
        if (!w_onehot)                             w_state_next = c_idle;
        else if (!w_changed && r_cnt == c_cnt_max) w_state_next = c_captured;
      end
      c_captured: begin
        if (w_changed) w_state_next = w_onehot ? c_settle : c_idle;
      end
      default: w_state_next = c_idle;
    endcase
  end

  always_comb begin
    w_capture = (r_state == c_settle) && w_onehot && !w_changed && (r_cnt == c_cnt_max);
  end

  always_comb begin
    w_known = 1'b1;
    w_nib   = 4'h0;
`ifdef SEG7CAP_BLANK_EN
    w_is_blank = 1'b0;
`endif
    case (w_seg)
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1011000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0010000: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b0000011: w_nib = 4'hB;
      7'b1000110: w_nib = 4'hC;
      7'b0100001: w_nib = 4'hD;
      7'b0000110: w_nib = 4'hE;
      7'b0001110: w_nib = 4'hF;
`ifdef SEG7CAP_BLANK_EN
      7'b1111111: w_is_blank = 1'b1;
`endif
      default:    w_known = 1'b0;
    endcase
  end

  assign w_cap_ok  = w_capture && w_known;
  assign w_cap_bad = w_capture && !w_known;
  assign w_publish = (r_seen == c_all_seen);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= 4'h0;
    end else if (w_cap_ok) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_dig[i]) r_shadow[i] <= w_nib;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_flat
    assign w_shadow_flat[4*gi +: 4] = r_shadow[gi];
  end

`ifdef SEG7CAP_BLANK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank_shadow <= '0;
    end else if (w_cap_ok) begin
      r_blank_shadow <= (r_blank_shadow & ~w_dig) | (w_is_blank ? w_dig : '0);
    end
  end
`endif

  // Publish clears the mask first so a same-cycle capture would still count toward the next frame.
  always_comb begin
    w_seen_next = w_publish ? '0 : r_seen;
    if (w_cap_ok) w_seen_next = w_seen_next | w_dig;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seen     <= '0;
      value      <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
`ifdef SEG7CAP_BLANK_EN
      blank_mask <= '0;
`endif
    end else begin
      r_seen     <= w_seen_next;
      frame_done <= w_publish;
      if (w_publish) begin
        value <= w_shadow_flat;
        valid <= 1'b1;
`ifdef SEG7CAP_BLANK_EN
        blank_mask <= r_blank_shadow;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (w_cap_bad) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

endmodule
`default_nettype wire
